// File: rtl/hex_disp_scan_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package hex_disp_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_seg_rom.sv
// Registered hex-to-seven-segment ROM, one cycle of latency.
module hex_seg_rom
  import hex_disp_scan_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] addr,
  output logic [6:0] data
);

  logic [6:0] seg_c;

  // Nibble decode to the active-low segment pattern
  always_comb begin
    seg_c = SEG_OFF;
    case (addr)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_OFF;
    endcase
  end

  // Output register; the scan top aligns anodes to this edge
  always_ff @(posedge clk) begin
    data <= seg_c;
  end

endmodule

// File: rtl/hex_disp_scan.sv
// Time-multiplexed four-digit common-anode seven-segment driver.
// A 16-bit value is snapshotted once per scan frame; each digit is lit
// for 2^(N-2) cycles. Anode enables are registered on the same edge as
// the segment ROM so a new anode never shows stale segments.
// Optional build macro HEX_DISP_SCAN_LZ_BLANK_EN adds leading-zero
// suppression on digits 3..1.
module hex_disp_scan
  import hex_disp_scan_pkg::*;
#(
  parameter int N = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_tick
);

  localparam logic [N-1:0] CNT_LAST = '1;
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

  // Active-low one-hot anode for the selected digit
  function automatic logic [3:0] digit_an(input logic [SEL_W-1:0] s);
    return ~(4'b0001 << s);
  endfunction

`ifdef HEX_DISP_SCAN_LZ_BLANK_EN
  // Digit k (3..1) goes dark when it and every digit above it are zero
  function automatic logic [3:0] lz_mask(input logic [15:0] h);
    logic [3:0] m;
    m[3] = (h[15:12] == 4'h0);
    m[2] = m[3] && (h[11:8] == 4'h0);
    m[1] = m[2] && (h[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  logic [N-1:0]       cnt_p0;
  logic [SEL_W-1:0]   sel_p0;
  logic               last_p0;
  logic [15:0]        hex_snap;
  logic [3:0]         dp_snap;
  logic [3:0]         blank_snap;
  logic [3:0]         nib_p0;
  logic [3:0]         blank_eff_p0;
  logic               blank_sel_p0;

  logic [6:0]         rom_data_p1;
  logic [3:0]         an_p1;
  logic               dp_p1;
  logic               vld_p1;

  // ---- stage p0: refresh counter, snapshot and digit select ----
  assign sel_p0  = cnt_p0[N-1:N-2];
  assign last_p0 = (cnt_p0 == CNT_LAST);

  // Free-running refresh counter, wraps naturally at 2^N
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_ONE;
    end
  end

  // Frame snapshot, taken only on the last cycle so a frame never mixes values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_snap   <= '0;
      dp_snap    <= '0;
      blank_snap <= '0;
    end else if (last_p0) begin
      hex_snap   <= hex_in;
      dp_snap    <= dp_in;
      blank_snap <= blank_in;
    end
  end

  // Per-digit dark mask combining the user mask and optional zero suppression
  always_comb begin
`ifdef HEX_DISP_SCAN_LZ_BLANK_EN
    blank_eff_p0 = blank_snap | lz_mask(hex_snap);
`else
    blank_eff_p0 = blank_snap;
`endif
  end

  assign nib_p0       = hex_snap[{sel_p0, 2'b00} +: 4];
  assign blank_sel_p0 = blank_eff_p0[sel_p0];

  // ---- stage p1: ROM output and aligned anode / dp registers ----
  hex_seg_rom u_rom (
    .clk  (clk),
    .addr (nib_p0),
    .data (rom_data_p1)
  );

  // Anode and dp registered on the ROM edge; a dark digit drops its dp too
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p1  <= AN_OFF;
      dp_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      an_p1  <= blank_sel_p0 ? AN_OFF : digit_an(sel_p0);
      dp_p1  <= dp_snap[sel_p0] & ~blank_sel_p0;
      vld_p1 <= 1'b1;
    end
  end

  // The ROM register has no reset; force all segments off until it is loaded
  assign sseg       = vld_p1 ? {~dp_p1, rom_data_p1} : {1'b1, SEG_OFF};
  assign an         = an_p1;
  assign frame_tick = last_p0;

endmodule
